// File: rtl/usb_rx_sipo_if.sv
// usb_rx_sipo_if: decoded bit stream in, fifo write strobe and packet status out of the receive SIPO
interface usb_rx_sipo_if #(parameter int BYTE_CNT_WIDTH = 11);
    logic                      serial_data_in;
    logic                      serial_data_in_val;
    logic                      serial_data_in_last;
    logic                      fifo_full;
    logic [7:0]                w_data;
    logic                      wr_en;
    logic                      pkt_done;
    logic                      pkt_err;
    logic [1:0]                err_code;
    logic [BYTE_CNT_WIDTH-1:0] byte_count;
    logic                      sipo_empty;
    modport master (
        output serial_data_in, serial_data_in_val, serial_data_in_last, fifo_full,
        input  w_data, wr_en, pkt_done, pkt_err, err_code, byte_count, sipo_empty
    );
    modport slave (
        input  serial_data_in, serial_data_in_val, serial_data_in_last, fifo_full,
        output w_data, wr_en, pkt_done, pkt_err, err_code, byte_count, sipo_empty
    );
endinterface

// File: rtl/usb_rx_sipo.sv
// usb_rx_sipo: removes stuffed bits, assembles LSB-first bytes into a one-entry hold for the rx fifo
module usb_rx_sipo #(
    parameter int MAX_STUFF_RUN  = 6,
    parameter int BYTE_CNT_WIDTH = 11
) (
    input logic          clk,
    input logic          rst,
    usb_rx_sipo_if.slave rx
);
    localparam int OW = $clog2(MAX_STUFF_RUN + 1);
    typedef enum logic [1:0] {IDLE, RECV, FLUSH, DISCARD} state_e;
    state_e                    state_q, state_d;
    logic [7:0]                shift_q, shift_d, hold_q, hold_d, shifted;
    logic [2:0]                bit_cnt_q, bit_cnt_d;
    logic [OW-1:0]             ones_q, ones_d;
    logic                      hold_vld_q, hold_vld_d, done_q, done_d, err_q, err_d;
    logic [1:0]                code_q, code_d, code;
    logic [BYTE_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                      wr, take, stuffed, full_byte, ovf, partial;
    assign wr        = hold_vld_q && !rx.fifo_full;
    assign take      = rx.serial_data_in_val && (state_q == IDLE || state_q == RECV);
    assign stuffed   = ones_q == OW'(MAX_STUFF_RUN);
    assign shifted   = {rx.serial_data_in, shift_q[7:1]};
    assign full_byte = !stuffed && bit_cnt_q == 3'd7;
    // a full hold that the fifo is not draining this cycle cannot take the new byte
    assign ovf       = full_byte && hold_vld_q && rx.fifo_full;
    assign partial   = stuffed ? bit_cnt_q != 3'd0 : !full_byte;
    assign code      = (stuffed && rx.serial_data_in) ? 2'b01 :
                       ovf ? 2'b11 :
                       (rx.serial_data_in_last && partial) ? 2'b10 : 2'b00;
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        bit_cnt_d  = bit_cnt_q;
        ones_d     = ones_q;
        hold_vld_d = hold_vld_q && !wr;
        code_d     = code_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        if (take) begin
            state_d   = RECV;
            cnt_d     = state_q == IDLE ? '0 : cnt_q;
            code_d    = state_q == IDLE ? 2'b00 : code_q;
            shift_d   = stuffed ? shift_q : shifted;
            bit_cnt_d = stuffed ? bit_cnt_q : bit_cnt_q + 3'd1;
            ones_d    = (stuffed || !rx.serial_data_in) ? '0 : ones_q + OW'(1);
            if (full_byte && !ovf) begin
                hold_d     = shifted;
                hold_vld_d = 1'b1;
                cnt_d      = &cnt_q ? cnt_q : cnt_q + BYTE_CNT_WIDTH'(1);
            end
            err_d = code != 2'b00;
            if (err_d) code_d = code;
            if (err_d || rx.serial_data_in_last) begin
                shift_d   = '0;
                bit_cnt_d = '0;
                ones_d    = '0;
                state_d   = rx.serial_data_in_last ? FLUSH : DISCARD;
            end
        end else if (state_q == DISCARD && rx.serial_data_in_val && rx.serial_data_in_last) begin
            state_d = FLUSH;
        end else if (state_q == FLUSH && !hold_vld_q) begin
            state_d = IDLE;
            done_d  = code_q == 2'b00;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            hold_q     <= '0;
            bit_cnt_q  <= '0;
            ones_q     <= '0;
            hold_vld_q <= 1'b0;
            code_q     <= 2'b00;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            bit_cnt_q  <= bit_cnt_d;
            ones_q     <= ones_d;
            hold_vld_q <= hold_vld_d;
            code_q     <= code_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end
    assign rx.w_data     = hold_q;
    assign rx.wr_en      = wr;
    assign rx.pkt_done   = done_q;
    assign rx.pkt_err    = err_q;
    assign rx.err_code   = code_q;
    assign rx.byte_count = cnt_q;
    assign rx.sipo_empty = state_q == IDLE && !hold_vld_q;
endmodule

// File: tb/tb_usb_rx_sipo.sv
// tb_usb_rx_sipo: directed and random packets checked against an array-level destuff/byte model
module tb_usb_rx_sipo;
  logic clk = 0;
  logic rst = 1;
  usb_rx_sipo_if bus();
  usb_rx_sipo dut(.clk(clk), .rst(rst), .rx(bus));
  always #5 clk = ~clk;
  int n_checks = 0, n_fail = 0, n_done = 0, n_err = 0, exp_cnt = 0;
  logic q_bits[$];
  logic [7:0] exp_q[$];
  logic [1:0] exp_code = 0;
  int stuff_pos[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) q_bits.push_back(v[i]);
  endtask
  task automatic put_byte(input logic [7:0] d, inout int run);
    for (int j = 0; j < 8; j++) begin
      q_bits.push_back(d[j]);
      run = d[j] ? run + 1 : 0;
      if (run == 6) begin
        stuff_pos.push_back(q_bits.size());
        q_bits.push_back(1'b0);
        run = 0;
      end
    end
  endtask
  // walk the line bits: after six 1s the next bit must be a 0 and is not data
  function automatic void model();
    int run = 0, nd = 0;
    logic [7:0] acc = 0;
    exp_q.delete();
    exp_code = 0;
    exp_cnt = 0;
    for (int i = 0; i < q_bits.size(); i++) begin
      if (run == 6) begin
        if (q_bits[i]) begin
          exp_code = 1;
          return;
        end
        run = 0;
        continue;
      end
      acc[nd % 8] = q_bits[i];
      nd++;
      run = q_bits[i] ? run + 1 : 0;
      if (nd % 8 == 0) begin
        exp_q.push_back(acc);
        if (exp_cnt < 2047) exp_cnt++;
      end
    end
    if (nd % 8 != 0) exp_code = 2;
  endfunction
  task automatic drive(input int from, input int to, input int maxgap);
    for (int i = from; i <= to; i++) begin
      repeat ($urandom_range(0, maxgap)) begin
        bus.serial_data_in = 1'($urandom);
        bus.serial_data_in_last = 1'($urandom);
        step();
      end
      bus.serial_data_in = q_bits[i];
      bus.serial_data_in_val = 1;
      bus.serial_data_in_last = (i == q_bits.size() - 1);
      step();
      bus.serial_data_in_val = 0;
      bus.serial_data_in_last = 0;
    end
  endtask
  task automatic start_pkt();
    n_done = 0;
    n_err = 0;
    q_bits.delete();
    stuff_pos.delete();
  endtask
  task automatic finish_pkt();
    int k = 0;
    while (!bus.sipo_empty && k < 200) begin
      step();
      k++;
    end
    chk("sipo_empty", bus.sipo_empty, 1);
    repeat (2) step();
    chk("done_pulses", n_done, exp_code == 0);
    chk("err_pulses", n_err, exp_code != 0);
    chk("bytes_left", exp_q.size(), 0);
    chk("byte_count", bus.byte_count, exp_cnt);
    chk("err_code", bus.err_code, exp_code);
    exp_q.delete();
  endtask
  task automatic check_reset();
    chk("rst_w_data", bus.w_data, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_pkt_done", bus.pkt_done, 0);
    chk("rst_pkt_err", bus.pkt_err, 0);
    chk("rst_err_code", bus.err_code, 0);
    chk("rst_byte_count", bus.byte_count, 0);
    chk("rst_sipo_empty", bus.sipo_empty, 1);
  endtask
  task automatic gen_pkt();
    int run = 0;
    int nb = $urandom_range(1, 4);
    int kind = $urandom_range(0, 3);
    for (int b = 0; b < nb; b++) put_byte(($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom), run);
    if (kind == 2) repeat ($urandom_range(1, 7)) q_bits.push_back(1'($urandom));
    if (kind == 3) begin
      if (stuff_pos.size() != 0) q_bits[stuff_pos[$urandom_range(0, stuff_pos.size() - 1)]] = 1'b1;
      else repeat (7) q_bits.push_back(1'b1);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    if (bus.wr_en) begin
      chk("wr_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("w_data", bus.w_data, exp_q.pop_front());
    end
    if (bus.pkt_done) begin
      n_done++;
      chk("done_byte_count", bus.byte_count, exp_cnt);
    end
    if (bus.pkt_err) begin
      n_err++;
      chk("pkt_err_code", bus.err_code, exp_code);
    end
    chk("done_err_excl", bus.pkt_done && bus.pkt_err, 0);
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.serial_data_in = 0;
    bus.serial_data_in_val = 0;
    bus.serial_data_in_last = 0;
    bus.fifo_full = 0;
    repeat (3) step();
    check_reset();
    rst = 0;
    step();
    start_pkt();
    load(32'h3CA5, 16);
    model();
    drive(0, 7, 0);
    chk("t1_wr_a5", bus.wr_en, 1);
    chk("t1_wdata_a5", bus.w_data, 8'hA5);
    drive(8, 15, 0);
    chk("t1_wr_3c", bus.wr_en, 1);
    chk("t1_wdata_3c", bus.w_data, 8'h3C);
    step();
    chk("t1_done_early", bus.pkt_done, 0);
    step();
    chk("t1_done", bus.pkt_done, 1);
    chk("t1_count", bus.byte_count, 2);
    chk("t1_code", bus.err_code, 0);
    finish_pkt();
    start_pkt();
    load(32'h1BF, 9);
    model();
    drive(0, 8, 0);
    finish_pkt();
    chk("t2_hold", bus.w_data, 8'hFF);
    chk("t2_count", bus.byte_count, 1);
    start_pkt();
    load(32'h97F, 12);
    model();
    drive(0, 6, 0);
    chk("t3_err", bus.pkt_err, 1);
    chk("t3_code", bus.err_code, 1);
    drive(7, 11, 2);
    finish_pkt();
    chk("t3_empty", bus.sipo_empty, 1);
    chk("t3_count", bus.byte_count, 0);
    start_pkt();
    load(32'h95A, 12);
    model();
    drive(0, 7, 0);
    chk("t4_wr", bus.wr_en, 1);
    chk("t4_wdata", bus.w_data, 8'h5A);
    drive(8, 11, 0);
    chk("t4_err", bus.pkt_err, 1);
    chk("t4_code", bus.err_code, 2);
    finish_pkt();
    chk("t4_count", bus.byte_count, 1);
    start_pkt();
    load(32'h2211, 16);
    load(32'h0, 1);
    exp_q.push_back(8'h11);
    exp_code = 3;
    exp_cnt = 1;
    bus.fifo_full = 1;
    drive(0, 15, 0);
    chk("t5_err", bus.pkt_err, 1);
    chk("t5_code", bus.err_code, 3);
    drive(16, 16, 0);
    repeat (3) step();
    chk("t5_not_empty", bus.sipo_empty, 0);
    chk("t5_no_wr", bus.wr_en, 0);
    bus.fifo_full = 0;
    finish_pkt();
    start_pkt();
    load(32'h15, 5);
    drive(0, 4, 0);
    chk("t6_busy", bus.sipo_empty, 0);
    rst = 1;
    #1;
    check_reset();
    step();
    rst = 0;
    step();
    start_pkt();
    load(32'h81, 8);
    model();
    drive(0, 7, 1);
    finish_pkt();
    chk("t6_wdata", bus.w_data, 8'h81);
    for (int p = 0; p < 40; p++) begin
      start_pkt();
      gen_pkt();
      model();
      drive(0, q_bits.size() - 1, 3);
      finish_pkt();
    end
    start_pkt();
    begin
      int run = 0;
      for (int i = 0; i < 2050; i++) put_byte(8'(i * 37), run);
    end
    model();
    chk("sat_model_cnt", exp_cnt, 2047);
    drive(0, q_bits.size() - 1, 0);
    finish_pkt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
